// File: rtl/traffic_pkg.sv
// Shared phase codes and default interval lengths for the intersection
// phase scheduler and its testbench.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_GA   = 3'd0,
    PH_YA   = 3'd1,
    PH_RAB  = 3'd2,
    PH_GB   = 3'd3,
    PH_YB   = 3'd4,
    PH_RBA  = 3'd5,
    PH_WALK = 3'd6
  } phase_e;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_MIN_GREEN = 6;
  localparam int DEF_MAX_GREEN = 20;
  localparam int DEF_YELLOW    = 3;
  localparam int DEF_ALL_RED   = 1;
  localparam int DEF_WALK      = 5;

endpackage

// File: rtl/phase_timer.sv
// Elapsed-cycles counter for the current phase: cleared on phase entry,
// counts enabled cycles, saturates at MAX_CNT, freezes while enable is low.
module phase_timer #(
  parameter int CNT_W   = 8,
  parameter int MAX_CNT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] elapsed
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // next count: clear wins, otherwise count up to the saturation value
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (clear)          cnt_d = '0;
      else if (cnt_q < SAT) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign elapsed = cnt_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase sequencer with latched sensor requests,
// min/max green, fixed yellow and all-red clearance.
// Macro PED_PHASE_EN builds the pedestrian WALK phase, ped_pend latch and
// next_dir bit; without it ped_req is ignored and walk is tied low.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_GREEN = DEF_MAX_GREEN,
  parameter int YELLOW    = DEF_YELLOW,
  parameter int ALL_RED   = DEF_ALL_RED,
  parameter int WALK      = DEF_WALK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       Sa,
  input  logic       Sb,
  input  logic       ped_req,
  output logic       R_a,
  output logic       Y_a,
  output logic       G_a,
  output logic       R_b,
  output logic       Y_b,
  output logic       G_b,
  output logic       walk,
  output logic [2:0] phase
);

  // last-cycle values of elapsed for each interval
  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_M1  = CNT_W'(ALL_RED - 1);

  phase_e           phase_d, phase_q;
  logic             req_a_d, req_a_q, req_b_d, req_b_q;
  logic             phase_chg, ped_go, ga_exit, gb_exit;
  logic [CNT_W-1:0] elapsed;

`ifdef PED_PHASE_EN
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK - 1);
  logic ped_pend_d, ped_pend_q, next_dir_d, next_dir_q;  // next_dir: 1 = B green follows walk
  assign ped_go = ped_pend_q;
  assign walk   = (phase_q == PH_WALK);
`else
  // ped_req and WALK have no role without the pedestrian phase
  logic unused_ped;
  assign unused_ped = ped_req ^ (WALK != 0);
  assign ped_go     = 1'b0;
  assign walk       = 1'b0;
`endif

  phase_timer #(.CNT_W(CNT_W), .MAX_CNT(MAX_GREEN)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (phase_chg),
    .enable (enable),
    .elapsed(elapsed)
  );

  // a green may end once minimum time is served and the other road (or a
  // pedestrian) waits; an own-road sensor still high holds it to max green
  assign ga_exit = (elapsed >= MIN_M1) &&
                   ((req_b_q && (!Sa || elapsed >= MAX_M1)) || ped_go);
  assign gb_exit = (elapsed >= MIN_M1) &&
                   ((req_a_q && (!Sb || elapsed >= MAX_M1)) || ped_go);

  // next phase
  always_comb begin
    phase_d = phase_q;
    if (enable) begin
      case (phase_q)
        PH_GA:  if (ga_exit)          phase_d = PH_YA;
        PH_YA:  if (elapsed == YEL_M1) phase_d = PH_RAB;
        PH_GB:  if (gb_exit)          phase_d = PH_YB;
        PH_YB:  if (elapsed == YEL_M1) phase_d = PH_RBA;
`ifdef PED_PHASE_EN
        PH_RAB:  if (elapsed == AR_M1)   phase_d = ped_pend_q ? PH_WALK : PH_GB;
        PH_RBA:  if (elapsed == AR_M1)   phase_d = ped_pend_q ? PH_WALK : PH_GA;
        PH_WALK: if (elapsed == WALK_M1) phase_d = next_dir_q ? PH_RAB : PH_RBA;
`else
        PH_RAB: if (elapsed == AR_M1) phase_d = PH_GB;
        PH_RBA: if (elapsed == AR_M1) phase_d = PH_GA;
`endif
        default: phase_d = PH_GA;
      endcase
    end
  end

  assign phase_chg = (phase_d != phase_q);

  // request latches: a live sensor re-sets its latch even on the entry edge
  always_comb begin
    req_a_d = req_a_q;
    req_b_d = req_b_q;
    if (enable) begin
      req_a_d = Sa | (req_a_q & ~(phase_chg && phase_d == PH_GA));
      req_b_d = Sb | (req_b_q & ~(phase_chg && phase_d == PH_GB));
    end
  end

  // phase and vehicle request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_GA;
      req_a_q <= 1'b0;
      req_b_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      req_a_q <= req_a_d;
      req_b_q <= req_b_d;
    end
  end

`ifdef PED_PHASE_EN
  // pedestrian latch; next_dir remembers which green follows the walk
  always_comb begin
    ped_pend_d = ped_pend_q;
    next_dir_d = next_dir_q;
    if (enable) begin
      ped_pend_d = ped_req | (ped_pend_q & ~(phase_chg && phase_d == PH_WALK));
      if (phase_chg && phase_d == PH_WALK) next_dir_d = (phase_q == PH_RAB);
    end
  end

  // pedestrian registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pend_q <= 1'b0;
      next_dir_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      next_dir_q <= next_dir_d;
    end
  end
`endif

  // Moore lamp decode straight off the phase register
  always_comb begin
    {R_a, Y_a, G_a, R_b, Y_b, G_b} = 6'b100_100;
    case (phase_q)
      PH_GA:   {R_a, Y_a, G_a, R_b, Y_b, G_b} = 6'b001_100;
      PH_YA:   {R_a, Y_a, G_a, R_b, Y_b, G_b} = 6'b010_100;
      PH_GB:   {R_a, Y_a, G_a, R_b, Y_b, G_b} = 6'b100_001;
      PH_YB:   {R_a, Y_a, G_a, R_b, Y_b, G_b} = 6'b100_010;
      default: {R_a, Y_a, G_a, R_b, Y_b, G_b} = 6'b100_100;
    endcase
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed, table-driven bench for intersection_phase_scheduler: one record
// per clock cycle holding the inputs and the phase expected during that cycle.
module tb_intersection_phase_scheduler;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b1, Sa = 1'b0, Sb = 1'b0, ped_req = 1'b0;
  logic R_a, Y_a, G_a, R_b, Y_b, G_b, walk;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  intersection_phase_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .Sa(Sa), .Sb(Sb),
    .ped_req(ped_req), .R_a(R_a), .Y_a(Y_a), .G_a(G_a), .R_b(R_b),
    .Y_b(Y_b), .G_b(G_b), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, sa, sb, en, ped, chk;
    logic [2:0] ph;
  } vec_t;

  vec_t vq[$];

  // required lamps {R_a,Y_a,G_a,R_b,Y_b,G_b,walk} for a phase
  function automatic logic [6:0] lamps_of(input logic [2:0] ph);
    case (ph)
      3'd0:    return 7'b001_100_0;
      3'd1:    return 7'b010_100_0;
      3'd3:    return 7'b100_001_0;
      3'd4:    return 7'b100_010_0;
      3'd6:    return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic push(input logic rst, sa, sb, en, ped, chk,
                      input logic [2:0] ph, input int n);
    vec_t v;
    v.rst = rst; v.sa = sa; v.sb = sb; v.en = en; v.ped = ped; v.chk = chk; v.ph = ph;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic push_reset();
    push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, PH_GA, 1);
  endtask

  task automatic check(input string name, input logic [2:0] ph);
    logic [6:0] got, req;
    got = {R_a, Y_a, G_a, R_b, Y_b, G_b, walk};
    req = lamps_of(ph);
    n_cmp++;
    if (phase !== ph || got !== req) begin
      n_bad++;
      $display("FAIL %s: got phase=%0d lamps=%b, required phase=%0d lamps=%b",
               name, phase, got, ph, req);
    end
  endtask

  initial begin
    // idle: rests in GA for 50 cycles
    push_reset();
    push(0, 0, 0, 1, 0, 1, PH_GA, 50);

    // Sb from cycle 2: GA 0-5, YA 6-8, RAB 9, GB from 10
    push_reset();
    push(0, 0, 0, 1, 0, 1, PH_GA, 2);
    push(0, 0, 1, 1, 0, 1, PH_GA, 4);
    push(0, 0, 1, 1, 0, 1, PH_YA, 3);
    push(0, 0, 1, 1, 0, 1, PH_RAB, 1);
    push(0, 0, 1, 1, 0, 1, PH_GB, 5);

    // both sensors held: max-green alternation
    push_reset();
    push(0, 1, 1, 1, 0, 1, PH_GA, 20);
    push(0, 1, 1, 1, 0, 1, PH_YA, 3);
    push(0, 1, 1, 1, 0, 1, PH_RAB, 1);
    push(0, 1, 1, 1, 0, 1, PH_GB, 20);
    push(0, 1, 1, 1, 0, 1, PH_YB, 3);
    push(0, 1, 1, 1, 0, 1, PH_RBA, 1);
    push(0, 1, 1, 1, 0, 1, PH_GA, 20);
    push(0, 1, 1, 1, 0, 1, PH_YA, 3);

    // enable low for 10 cycles from YA cycle 1: yellow resumes with 2 left
    push_reset();
    push(0, 0, 0, 1, 0, 1, PH_GA, 2);
    push(0, 0, 1, 1, 0, 1, PH_GA, 4);
    push(0, 0, 1, 1, 0, 1, PH_YA, 1);
    push(0, 0, 1, 0, 0, 1, PH_YA, 10);
    push(0, 0, 1, 1, 0, 1, PH_YA, 2);
    push(0, 0, 1, 1, 0, 1, PH_RAB, 1);
    push(0, 0, 1, 1, 0, 1, PH_GB, 3);

`ifdef PED_PHASE_EN
    // ped pulse at cycle 1: YA 6-8, RAB 9, WALK 10-14, RAB 15, GB from 16
    push_reset();
    push(0, 0, 0, 1, 0, 1, PH_GA, 1);
    push(0, 0, 0, 1, 1, 1, PH_GA, 1);
    push(0, 0, 0, 1, 0, 1, PH_GA, 4);
    push(0, 0, 0, 1, 0, 1, PH_YA, 3);
    push(0, 0, 0, 1, 0, 1, PH_RAB, 1);
    push(0, 0, 0, 1, 0, 1, PH_WALK, 5);
    push(0, 0, 0, 1, 0, 1, PH_RAB, 1);
    push(0, 0, 0, 1, 0, 1, PH_GB, 4);
`endif

    foreach (vq[i]) begin
      reset = vq[i].rst; Sa = vq[i].sa; Sb = vq[i].sb;
      enable = vq[i].en; ped_req = vq[i].ped;
      #1;
      if (vq[i].chk) check($sformatf("vec[%0d]", i), vq[i].ph);
      @(posedge clk); #1;
    end

    // reset during YB with a stale req_b pending
    reset = 1'b1; Sa = 1'b0; Sb = 1'b0; enable = 1'b1; ped_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 17; c++) begin
      Sa = (c == 10);
      Sb = (c < 3) || (c == 12);
      #1;
      if (c == 10) check("mid_gb", PH_GB);
      if (c == 16) check("mid_yb", PH_YB);
      @(posedge clk); #1;
    end
    Sa = 1'b0; Sb = 1'b0; reset = 1'b1;
    #1;
    check("pre_rst_yb", PH_YB);
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_ga", PH_GA);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c % 5 == 4) check($sformatf("stale_req_b_c%0d", c + 1), PH_GA);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Sequences the signal phases of a two-road intersection: road A and road B vehicle lights plus an optional pedestrian walk phase. It latches vehicle sensor requests, enforces minimum/maximum green, fixed yellow and all-red clearance intervals, and arbitrates green time between the two roads. It drives the R/Y/G lamp outputs for both roads directly. It supersedes the free-running controller as the phase sequencer of the intersection top level.

## Interface
- CNT_W, 8: width of the phase elapsed counter; must hold MAX_GREEN.
- MIN_GREEN, 6: minimum green cycles per road.
- MAX_GREEN, 20: green cycles after which a contested green is forced off.
- YELLOW, 3: yellow cycles.
- ALL_RED, 1: all-red clearance cycles.
- WALK, 5: pedestrian walk cycles. Used only with the macro.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 0, state, counter and latches freeze and outputs hold.
- Sa  in  1  road A vehicle sensor (level).
- Sb  in  1  road B vehicle sensor (level).
- ped_req  in  1  pedestrian button (pulse or level).
- R_a, Y_a, G_a  out  1 each  road A lamps (one-hot).
- R_b, Y_b, G_b  out  1 each  road B lamps (one-hot).
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current phase code.

## Operation
- Phases: GA=0, YA=1, RAB=2 (all-red after A), GB=3, YB=4, RBA=5 (all-red after B), WALK=6.
- Lamp outputs are a Moore decode of the phase register:
  - GA: G_a and R_b.
  - YA: Y_a and R_b.
  - GB: R_a and G_b.
  - YB: R_a and Y_b.
  - RAB, RBA, WALK: R_a and R_b.
  - walk=1 only in WALK.
- Elapsed counter: cleared to 0 on phase entry. Increments each enabled cycle and saturates at MAX_GREEN.
- Request latches req_a, req_b, ped_pend:
  - Set on any enabled cycle with Sa, Sb or ped_req high.
  - req_a is cleared on entry to GA; req_b on entry to GB; ped_pend on entry to WALK.
  - Set has priority over clear in the same cycle only if the sensor is still high on the entry cycle.
- GA exit to YA requires elapsed ≥ MIN_GREEN−1, plus one of:
  - req_b with Sa low;
  - req_b with elapsed ≥ MAX_GREEN−1;
  - ped_pend.
- GA with no pending request rests in green indefinitely. GB behaves symmetrically with A and B swapped.
- YA/YB: exit when elapsed = YELLOW−1, to RAB/RBA.
- RAB: exit when elapsed = ALL_RED−1. Goes to WALK if ped_pend, else GB. RBA likewise goes to WALK or GA.
- WALK:
  - On entry, a next_dir bit records the green that follows (B after RAB, A after RBA).
  - Exit when elapsed = WALK−1 to a final all-red: RAB if next_dir=B, RBA if next_dir=A.
  - That all-red then goes to the recorded green with no second walk, since ped_pend is already cleared.
- Simultaneous Sa and Sb: roads alternate, each green lasting MAX_GREEN cycles.
- enable=0 mid-phase: remaining time resumes exactly where it stopped.
- Reset values:
  - phase=GA, elapsed=0, all latches 0, next_dir=0.
  - G_a=1, R_b=1, all other lamps 0, walk=0.
- Reset mid-phase: GA on the next edge, regardless of the current phase.

## Timing
- Cycle 0 is the first cycle after reset deasserts, or the first cycle of a new phase.
- Phase durations in cycles: yellow exactly YELLOW, all-red exactly ALL_RED, walk exactly WALK.
- Green duration:
  - Minimum MIN_GREEN cycles.
  - A contested green (own sensor still high) lasts MAX_GREEN cycles.
- Sensor-to-latch latency: 1 cycle. A request seen at cycle n can first cause exit at the end of cycle n+1.
- Outputs change on the same edge as phase; there is no extra output register.

## Configuration
- PED_PHASE_EN defined:
  - WALK phase, ped_pend latch and next_dir are built.
  - ped_pend participates in green exit.
- PED_PHASE_EN undefined:
  - ped_req is ignored and walk is tied to 0.
  - Phase 6 does not exist; the port list is unchanged.

## Structure
- Shared package traffic_pkg holds:
  - phase code constants (PH_GA..PH_WALK);
  - the default timing constants, so the top level and testbenches share them.
- Sub-module phase_timer holds the elapsed counter:
  - inputs: clear, enable;
  - output: elapsed;
  - saturating at MAX_GREEN.

## Test plan
- Reset, Sa=Sb=0 for 50 cycles -> G_a=R_b=1 throughout, phase=0.
- Sb=1 from cycle 2, Sa=0 -> G_a cycles 0–5, Y_a cycles 6–8, all-red cycle 9, G_b from cycle 10.
- Sa=Sb=1 held -> GA 20 cycles, YA 3, RAB 1, GB 20, YB 3, RBA 1, repeating; phase trace 0,1,2,3,4,5.
- Sb=1 then enable=0 for 10 cycles in YA cycle 1 -> Y_a held 10 extra cycles, then exactly 2 more yellow cycles.
- PED_PHASE_EN, ped_req pulse at cycle 1, no Sb -> YA cycles 6–8, RAB 9, walk=1 with R_a=R_b=1 cycles 10–14, RAB 15, G_b from 16.
- reset pulse during YB -> next cycle G_a=R_b=1, phase=0, stale req_b cleared (no B green without new Sb).
